cmd_dispatcher: RTL and testbench

Command sequencer between the UART receiver/transmitter and the capture/readout engines (sampler, sample reader, replayer, reply counter). It decodes one opcode byte from `uart_rx` and activates exactly one engine. It routes that engine's byte stream to the shared `uart_tx`, and returns the system to idle when the engine reports done. A watchdog aborts a hung engine, and unknown opcodes get a NAK byte.

---
 rtl/cmd_dispatcher.sv | 149 ++++++++++++++
 tb/tb_cmd_dispatcher.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: decodes one opcode byte from the UART receiver, enables the
// matching capture/readout engine, forwards that engine's byte stream to the
// shared UART transmitter and returns to idle once the engine is done.
// Unknown opcodes answer with a NAK byte; a watchdog aborts a hung engine.
module cmd_dispatcher #(
  parameter int                 NUM_ENG        = 4,
  parameter logic [8*NUM_ENG-1:0] OPCODES      = {8'h72, 8'h71, 8'h22, 8'h21},
  parameter int                 TIMEOUT_CYCLES = 50_000_000,
  parameter int                 TO_W           = 26,
  parameter logic [7:0]         NAK_BYTE       = 8'h15,
  parameter logic [7:0]         TO_BYTE        = 8'hEE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_ready,
  input  logic [7:0]             rx_data,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic [NUM_ENG-1:0]     eng_activate,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [NUM_ENG-1:0]     eng_tx_start,
  input  logic [8*NUM_ENG-1:0]   eng_tx_data,
  output logic [7:0]             status,
  output logic                   err_timeout
);

  localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_SENDW = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic             rx_prev;
  logic             rx_strobe;
  logic [IDX_W-1:0] eng_idx;
  logic [7:0]       send_byte;
  logic [TO_W-1:0]  wd_count;
  logic             wd_expired;

  logic             op_match;
  logic [IDX_W-1:0] op_idx;
  logic             sel_done;
  logic             sel_tx_start;
  logic [7:0]       sel_tx_data;
  logic [NUM_ENG-1:0] sel_onehot;

  assign rx_strobe    = rx_ready & ~rx_prev;
  assign wd_expired   = (wd_count == WD_LAST);
  assign sel_done     = eng_done[eng_idx];
  assign sel_tx_start = eng_tx_start[eng_idx];
  assign sel_tx_data  = eng_tx_data[8*eng_idx +: 8];
  assign sel_onehot   = NUM_ENG'(1) << eng_idx;

  // Opcode lookup; scanning from the top down leaves the lowest matching index.
  always_comb begin
    op_match = 1'b0;
    op_idx   = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (rx_data == OPCODES[8*i +: 8]) begin
        op_match = 1'b1;
        op_idx   = IDX_W'(i);
      end
    end
  end

  // Previous rx_ready level; resets high so a level held through reset is no strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rx_prev <= 1'b1;
    else        rx_prev <= rx_ready;
  end

  // Command sequencer plus the registered tx path and status/error outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      eng_idx     <= '0;
      send_byte   <= 8'h00;
      status      <= 8'h00;
      err_timeout <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_strobe) begin
            if (op_match) begin
              eng_idx <= op_idx;
              status  <= rx_data;
              state   <= ST_RUN;
            end else begin
              send_byte <= NAK_BYTE;
              state     <= ST_SEND;
            end
          end
        end
        ST_RUN: begin
          if (sel_tx_start && (sel_done || !wd_expired)) begin
            tx_start <= 1'b1;
            tx_data  <= sel_tx_data;
          end
          if (sel_done) begin
            state <= ST_DRAIN;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
            send_byte   <= TO_BYTE;
            state       <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!tx_active) begin
            tx_start <= 1'b1;
            tx_data  <= send_byte;
            state    <= ST_SENDW;
          end
        end
        ST_SENDW: begin
          if (tx_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!tx_active && !rx_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Engine enable trails the state by one cycle, so it drops the cycle after leaving RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                eng_activate <= '0;
    else if (state == ST_RUN)  eng_activate <= sel_onehot;
    else                       eng_activate <= '0;
  end

  // Watchdog: held at zero outside RUN, counts RUN cycles and saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wd_count <= '0;
    else if (state != ST_RUN)   wd_count <= '0;
    else if (wd_count != '1)    wd_count <= wd_count + 1'b1;
  end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// tb_cmd_dispatcher: directed scenarios for cmd_dispatcher with a short watchdog.
module tb_cmd_dispatcher;

  logic        clk;
  logic        reset;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        tx_active;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  eng_activate;
  logic [3:0]  eng_done;
  logic [3:0]  eng_tx_start;
  logic [31:0] eng_tx_data;
  logic [7:0]  status;
  logic        err_timeout;

  int pass_cnt;
  int total_cnt;
  int tx_pulses;
  int act0_cycles;

  cmd_dispatcher #(
    .NUM_ENG(4),
    .OPCODES({8'h72, 8'h71, 8'h22, 8'h21}),
    .TIMEOUT_CYCLES(100),
    .TO_W(7),
    .NAK_BYTE(8'h15),
    .TO_BYTE(8'hEE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_ready(rx_ready),
    .rx_data(rx_data),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .eng_activate(eng_activate),
    .eng_done(eng_done),
    .eng_tx_start(eng_tx_start),
    .eng_tx_data(eng_tx_data),
    .status(status),
    .err_timeout(err_timeout)
  );

  // Free-running 100 MHz bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts tx_start pulses and engine-0 enable cycles, sampled on the inactive edge.
  always @(negedge clk) begin
    if (tx_start === 1'b1) tx_pulses = tx_pulses + 1;
    if (eng_activate[0] === 1'b1) act0_cycles = act0_cycles + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_ready = 1'b0; rx_data = 8'h00; tx_active = 1'b0; tx_done = 1'b0;
    eng_done = 4'h0; eng_tx_start = 4'h0; eng_tx_data = 32'h0;
    repeat (3) tick();
    total_cnt++;
    if ({tx_start, tx_data, eng_activate, status, err_timeout} !== 22'h0)
      $display("[TB] FAIL reset_vals: got %b want all zero",
               {tx_start, tx_data, eng_activate, status, err_timeout});
    else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_dispatch_done();
    int p0;
    p0 = tx_pulses;
    strobe_byte(8'h21);
    total_cnt++;
    if (eng_activate !== 4'b0000) $display("[TB] FAIL act_latency: got %b want 0000", eng_activate);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0001) $display("[TB] FAIL act_eng0: got %b want 0001", eng_activate);
    else pass_cnt++;
    total_cnt++;
    if (status !== 8'h21) $display("[TB] FAIL status_21: got %h want 21", status);
    else pass_cnt++;
    repeat (9) tick();
    eng_done = 4'b0001;
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0001) $display("[TB] FAIL act_hold_done: got %b want 0001", eng_activate);
    else pass_cnt++;
    tick();
    eng_done = 4'b0000;
    total_cnt++;
    if (eng_activate !== 4'b0000) $display("[TB] FAIL act_drop: got %b want 0000", eng_activate);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (tx_pulses - p0 !== 0) $display("[TB] FAIL no_tx_traffic: got %0d pulses want 0", tx_pulses - p0);
    else pass_cnt++;
  endtask

  task automatic test_routing();
    strobe_byte(8'h71);
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0100) $display("[TB] FAIL act_eng2: got %b want 0100", eng_activate);
    else pass_cnt++;
    eng_tx_data  = 32'h11_5A_22_33;
    eng_tx_start = 4'b1011;
    tick();
    eng_tx_start = 4'b0000;
    total_cnt++;
    if (tx_start !== 1'b0) $display("[TB] FAIL unsel_tx_start: got %b want 0", tx_start);
    else pass_cnt++;
    eng_tx_data  = 32'h11_A5_22_33;
    eng_tx_start = 4'b0100;
    tick();
    eng_tx_start = 4'b0000;
    total_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'hA5)
      $display("[TB] FAIL route_a5: got start=%b data=%h want start=1 data=a5", tx_start, tx_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (tx_start !== 1'b0) $display("[TB] FAIL route_single: got %b want 0", tx_start);
    else pass_cnt++;
    eng_tx_data  = 32'h00_3C_00_00;
    eng_tx_start = 4'b0100;
    eng_done     = 4'b0100;
    tick();
    eng_tx_start = 4'b0000;
    eng_done     = 4'b0000;
    total_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'h3C)
      $display("[TB] FAIL done_byte_fwd: got start=%b data=%h want start=1 data=3c", tx_start, tx_data);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0000 || tx_start !== 1'b0)
      $display("[TB] FAIL route_end: got act=%b start=%b want 0000/0", eng_activate, tx_start);
    else pass_cnt++;
  endtask

  task automatic test_nak();
    int p0;
    tick();
    p0 = tx_pulses;
    tx_active = 1'b1;
    strobe_byte(8'h42);
    repeat (3) tick();
    total_cnt++;
    if (tx_start !== 1'b0 || eng_activate !== 4'b0000)
      $display("[TB] FAIL nak_wait: got start=%b act=%b want 0/0000", tx_start, eng_activate);
    else pass_cnt++;
    tx_active = 1'b0;
    tick();
    total_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'h15)
      $display("[TB] FAIL nak_byte: got start=%b data=%h want start=1 data=15", tx_start, tx_data);
    else pass_cnt++;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    total_cnt++;
    if (tx_pulses - p0 !== 1) $display("[TB] FAIL nak_single: got %0d pulses want 1", tx_pulses - p0);
    else pass_cnt++;
    total_cnt++;
    if (status !== 8'h71) $display("[TB] FAIL nak_status: got %h want 71", status);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int p0;
    int a0;
    p0 = tx_pulses;
    a0 = act0_cycles;
    strobe_byte(8'h72);
    tick();
    total_cnt++;
    if (eng_activate !== 4'b1000) $display("[TB] FAIL act_eng3: got %b want 1000", eng_activate);
    else pass_cnt++;
    strobe_byte(8'h21);
    repeat (97) tick();
    eng_done = 4'b1000;
    tick();
    eng_done = 4'b0000;
    total_cnt++;
    if (err_timeout !== 1'b0) $display("[TB] FAIL done_beats_wd: got %b want 0", err_timeout);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (status !== 8'h72 || act0_cycles - a0 !== 0)
      $display("[TB] FAIL drop_strobe: got status=%h eng0_cycles=%0d want 72/0", status, act0_cycles - a0);
    else pass_cnt++;
    total_cnt++;
    if (tx_pulses - p0 !== 0 || eng_activate !== 4'b0000)
      $display("[TB] FAIL b2b_quiet: got pulses=%0d act=%b want 0/0000", tx_pulses - p0, eng_activate);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int hi_cnt;
    hi_cnt = 0;
    strobe_byte(8'h22);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (eng_activate === 4'b0010) hi_cnt++;
      else if (hi_cnt > 0) break;
    end
    total_cnt++;
    if (hi_cnt !== 100) $display("[TB] FAIL wd_cycles: got %0d want 100", hi_cnt);
    else pass_cnt++;
    total_cnt++;
    if (err_timeout !== 1'b1) $display("[TB] FAIL wd_flag: got %b want 1", err_timeout);
    else pass_cnt++;
    total_cnt++;
    if (tx_start !== 1'b1 || tx_data !== 8'hEE)
      $display("[TB] FAIL wd_byte: got start=%b data=%h want start=1 data=ee", tx_start, tx_data);
    else pass_cnt++;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    strobe_byte(8'h21);
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0001 || err_timeout !== 1'b1 || status !== 8'h21)
      $display("[TB] FAIL post_wd: got act=%b err=%b status=%h want 0001/1/21",
               eng_activate, err_timeout, status);
    else pass_cnt++;
    eng_done = 4'b0001;
    tick();
    tick();
    eng_done = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_run();
    strobe_byte(8'h21);
    tick();
    #2;
    reset    = 1'b0;
    rx_data  = 8'h21;
    rx_ready = 1'b1;
    #1;
    total_cnt++;
    if ({tx_start, tx_data, eng_activate, status, err_timeout} !== 22'h0)
      $display("[TB] FAIL async_reset: got %b want all zero",
               {tx_start, tx_data, eng_activate, status, err_timeout});
    else pass_cnt++;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    total_cnt++;
    if (eng_activate !== 4'b0000 || status !== 8'h00)
      $display("[TB] FAIL held_level: got act=%b status=%h want 0000/00", eng_activate, status);
    else pass_cnt++;
    rx_ready = 1'b0;
    tick();
    strobe_byte(8'h21);
    tick();
    total_cnt++;
    if (eng_activate !== 4'b0001 || status !== 8'h21)
      $display("[TB] FAIL redispatch: got act=%b status=%h want 0001/21", eng_activate, status);
    else pass_cnt++;
    eng_done = 4'b0001;
    tick();
    tick();
    eng_done = 4'b0000;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    pass_cnt = 0; total_cnt = 0; tx_pulses = 0; act0_cycles = 0;
    test_reset();
    test_dispatch_done();
    test_routing();
    test_nak();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
